matrix_transpose_mxp: RTL

//  Parametrised MxP matrix transpose engine with a backpressured streaming output.
//  - Host loads an MxP matrix, stored row-major, through a write port. The host then starts a frame.
//  - The block streams either the PxM transpose or the unmodified matrix, row by row, one element per handshake.
//  - Downstream of this block are the tracker's matrix multiply and filter-update blocks.

---
 rtl/matrix_transpose_mxp_pkg.sv | 9 +
 rtl/matrix_transpose_mxp_if.sv | 23 ++
 rtl/matrix_transpose_mxp_index_gen.sv | 41 ++++
 rtl/matrix_transpose_mxp.sv | 102 ++++++++++
 4 files changed

// File: rtl/matrix_transpose_mxp_pkg.sv
// mtx_pkg: shared FSM states, mode codes and index-width helper for the matrix blocks
package mtx_pkg;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;
   localparam logic MODE_TRANSPOSE = 1'b0;
   localparam logic MODE_PASS = 1'b1;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/matrix_transpose_mxp_if.sv
// matrix_transpose_mxp_if: load port, frame control and streaming output of the transpose engine
//   master drives start/mode/a_in/a_addr/a_wen/c_ready; slave drives c_out/c_valid/c_row/c_col/c_last/busy/done/wr_err
interface matrix_transpose_mxp_if #(
   parameter int M = 3,
   parameter int P = 3,
   parameter int DATA_WIDTH = 32
) ();
   import mtx_pkg::*;
   localparam int AW = idx_w(M * P);
   localparam int IW = idx_w(M > P ? M : P);
   logic start, mode, a_wen, c_valid, c_ready, c_last, busy, done, wr_err;
   logic signed [DATA_WIDTH-1:0] a_in, c_out;
   logic [AW-1:0] a_addr;
   logic [IW-1:0] c_row, c_col;
   modport master (
      output start, mode, a_in, a_addr, a_wen, c_ready,
      input c_out, c_valid, c_row, c_col, c_last, busy, done, wr_err
   );
   modport slave (
      input start, mode, a_in, a_addr, a_wen, c_ready,
      output c_out, c_valid, c_row, c_col, c_last, busy, done, wr_err
   );
endinterface

// File: rtl/matrix_transpose_mxp_index_gen.sv
// mtx_index_gen: row/col walker over the output matrix with last flag and row-major storage read address
//   i_clr restarts at (0,0); i_adv steps one element; i_row_max/i_col_max bound the walk;
//   i_mode selects transpose (A[c*P+r]) or pass-through (A[r*P+c]) addressing
module mtx_index_gen import mtx_pkg::*; #(
   parameter int M = 3,
   parameter int P = 3,
   localparam int AW = idx_w(M * P),
   localparam int IW = idx_w(M > P ? M : P)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_adv,
   input  logic          i_mode,
   input  logic [IW-1:0] i_row_max,
   input  logic [IW-1:0] i_col_max,
   output logic [IW-1:0] o_row,
   output logic [IW-1:0] o_col,
   output logic          o_last,
   output logic [AW-1:0] o_addr
);
   logic [IW-1:0] r_row, r_col;
   logic w_row_end;
   assign w_row_end = r_col == i_col_max;
   assign o_last = w_row_end && r_row == i_row_max;
   assign o_row = r_row;
   assign o_col = r_col;
   assign o_addr = i_mode == MODE_PASS ? AW'(r_row) * AW'(P) + AW'(r_col)
                                       : AW'(r_col) * AW'(P) + AW'(r_row);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_adv) begin
         r_col <= w_row_end ? '0 : r_col + 1'b1;
         r_row <= o_last ? '0 : w_row_end ? r_row + 1'b1 : r_row;
      end
endmodule

// File: rtl/matrix_transpose_mxp.sv
// matrix_transpose_mxp: MxP matrix store streamed out transposed or unchanged over a valid/ready port
//   clk, rst_n (async active-low); s: matrix_transpose_mxp_if.slave (load port, frame control, output stream)
//   MTX_TRANSPOSE_PINGPONG_EN: two banks so the next matrix loads while the current one streams
module matrix_transpose_mxp import mtx_pkg::*; #(
   parameter int M = 3,
   parameter int P = 3,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   matrix_transpose_mxp_if.slave s
);
   localparam int MP = M * P;
   localparam int AW = idx_w(MP);
   localparam int IW = idx_w(M > P ? M : P);
   localparam logic [AW:0] MP_W = (AW + 1)'(MP);
   state_t r_state;
   logic r_mode, r_c_valid, r_c_last, r_done, r_wr_err;
   logic signed [DATA_WIDTH-1:0] r_c_out, w_rd_data;
   logic [IW-1:0] r_c_row, r_c_col, w_row, w_col, w_row_max, w_col_max;
   logic [AW-1:0] w_rd_addr;
   logic w_last, w_start, w_load, w_wr_ok, w_in_range;
   assign w_start = r_state == S_IDLE && s.start;
   // Fetch the element under the index pointer on FETCH and on every non-final handshake
   assign w_load = r_state == S_FETCH || (r_state == S_STREAM && r_c_valid && s.c_ready && !r_c_last);
   assign w_in_range = {1'b0, s.a_addr} < MP_W;
   assign w_row_max = r_mode == MODE_PASS ? IW'(M - 1) : IW'(P - 1);
   assign w_col_max = r_mode == MODE_PASS ? IW'(P - 1) : IW'(M - 1);
   mtx_index_gen #(.M(M), .P(P)) u_idx (
      .clk(clk), .rst_n(rst_n), .i_clr(w_start), .i_adv(w_load), .i_mode(r_mode),
      .i_row_max(w_row_max), .i_col_max(w_col_max),
      .o_row(w_row), .o_col(w_col), .o_last(w_last), .o_addr(w_rd_addr)
   );
`ifdef MTX_TRANSPOSE_PINGPONG_EN
   logic r_wr_bank, r_rd_bank;
   logic signed [DATA_WIDTH-1:0] r_mem [2][MP];
   assign w_wr_ok = w_in_range;
   assign w_rd_data = r_mem[r_rd_bank][w_rd_addr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
      end else if (w_start) begin
         r_rd_bank <= r_wr_bank;
         r_wr_bank <= ~r_wr_bank;
      end
   // A write alongside the accepted start still lands in the bank the frame will read
   always_ff @(posedge clk)
      if (s.a_wen && w_wr_ok) r_mem[r_wr_bank][s.a_addr] <= s.a_in;
`else
   logic signed [DATA_WIDTH-1:0] r_mem [MP];
   assign w_wr_ok = w_in_range && r_state == S_IDLE;
   assign w_rd_data = r_mem[w_rd_addr];
   always_ff @(posedge clk)
      if (s.a_wen && w_wr_ok) r_mem[s.a_addr] <= s.a_in;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_mode <= MODE_TRANSPOSE;
         r_c_out <= '0;
         r_c_valid <= 1'b0;
         r_c_row <= '0;
         r_c_col <= '0;
         r_c_last <= 1'b0;
         r_done <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wr_err <= s.a_wen && !w_wr_ok;
         if (w_load) begin
            r_c_out <= w_rd_data;
            r_c_row <= w_row;
            r_c_col <= w_col;
            r_c_last <= w_last;
         end
         case (r_state)
            S_IDLE: if (s.start) begin
               r_mode <= s.mode;
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               r_c_valid <= 1'b1;
               r_state <= S_STREAM;
            end
            S_STREAM: if (r_c_valid && s.c_ready && r_c_last) begin
               r_c_valid <= 1'b0;
               r_done <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: r_state <= S_IDLE;
         endcase
      end
   assign s.c_out = r_c_out;
   assign s.c_valid = r_c_valid;
   assign s.c_row = r_c_row;
   assign s.c_col = r_c_col;
   assign s.c_last = r_c_last;
   assign s.busy = r_state != S_IDLE;
   assign s.done = r_done;
   assign s.wr_err = r_wr_err;
endmodule
